image_scan_ctrl: RTL and testbench
==================================

IMAGE_SCAN_CTRL -- requirements
Module: image_scan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1, request to scan one image window.
REQ-004 SHALL have port width, input, 10, number of columns to scan; sampled only on accepted start.
REQ-005 SHALL have port height, input, 10, number of rows to scan; sampled only on accepted start.
REQ-006 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have ports rom_x and rom_y, output, 10 each, registered pixel address driven to the image loader.
REQ-009 SHALL have ports rom_r, rom_g and rom_b, input, 8 each, image loader data, valid exactly one cycle after the address.
REQ-010 SHALL have port pix_data, output, 24, packed as {r,g,b}.
REQ-011 SHALL have port pix_valid, output, 1, output beat valid.
REQ-012 SHALL have port pix_ready, input, 1, sink accepts beat.
REQ-013 SHALL have port pix_eol, output, 1, beat is the last pixel of a row.
REQ-014 SHALL have port pix_last, output, 1, beat is the final pixel of the window.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> DRAIN -> IDLE.
REQ-016 SHALL accept start only in IDLE with busy=0; start in any other state SHALL be ignored.
REQ-017 SHALL take IDLE->SCAN on accepted start with width>0 and height>0.
REQ-018 SHALL take SCAN->DRAIN after issuing address (width-1, height-1).
REQ-019 SHALL take DRAIN->IDLE on the handshake of the pix_last beat.
REQ-020 SHALL, on accepted start with width=0 or height=0, stay in IDLE, emit no beats, and pulse done in the next cycle.
REQ-021 SHALL scan raster order: x increments 0..width-1, then x wraps to 0 and y increments, through y=height-1.
REQ-022 SHALL define a handshake as pix_valid & pix_ready; pix_data, pix_eol and pix_last SHALL be held stable while pix_valid=1 and pix_ready=0.
REQ-023 SHALL buffer ROM data in a 2-entry FIFO.
REQ-024 SHALL issue a new address only when fifo_count + inflight - handshake < 2; ROM data SHALL never be dropped.
REQ-025 SHALL hold rom_x and rom_y at their last value when not issuing, and at 0 in IDLE.
REQ-026 SHALL meet this latency: start sampled at edge of cycle N; (0,0) presented in N+1; first pix_valid in N+3.
REQ-027 SHALL sustain one beat per cycle while pix_ready=1, so the last beat is in N+2+width*height.
REQ-028 SHALL assert done for one cycle in the first IDLE cycle after the last handshake, with busy=0; a start in that cycle SHALL be accepted.
REQ-029 SHALL resume with no loss or duplication when pix_ready deasserts for an arbitrary number of cycles mid-row, mid-wrap or on the last beat.
REQ-030 SHALL treat width=1 as every beat having pix_eol=1, and width=1, height=1 as a single beat with pix_eol=1 and pix_last=1.

Reset
REQ-031 SHALL, on rst=1, asynchronously force: state IDLE; busy, done, pix_valid, pix_eol, pix_last = 0; pix_data, rom_x, rom_y = 0; FIFO and inflight cleared.
REQ-032 SHALL discard any in-flight ROM data when reset is asserted mid-scan.
REQ-033 SHALL remain in IDLE after rst deasserts, with no beat emitted until a new start.

Structure
REQ-034 SHALL define COORD_W=10, PIX_W=24 and the FSM state enum in shared package img_pkg.
REQ-035 SHALL place the 2-entry buffer in sub-module pix_fifo2, which carries data, eol and last.
REQ-036 SHALL keep the image loader outside this block, connected only through the rom_* ports.

Verification
REQ-037 SHALL cover: width=3, height=2, ready=1 -> 6 beats in cycles N+3..N+8; eol on beats 3 and 6; last on beat 6; done in N+9.
REQ-038 SHALL cover: width=4, height=2, ready toggled pseudo-randomly -> 8 beats matching the ROM model at (x,y) in raster order; no duplicates; data stable during stalls.
REQ-039 SHALL cover: width=0, height=5 -> no pix_valid; done pulse one cycle after start; busy stays 0.
REQ-040 SHALL cover: start pulsed while busy with width=2, height=2 -> ignored; only the original window's beats appear.
REQ-041 SHALL cover: rst asserted at beat 3 of a 3x3 scan -> pix_valid=0 immediately; after release plus start with width=1, height=1 -> single beat of pixel (0,0) with eol=1 and last=1.
REQ-042 SHALL cover: start held high through done with width=2, height=1 -> back-to-back windows; second window's first pix_valid 3 cycles after the done cycle.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image scan controller: widths, FSM states and
// a small coordinate helper.
package img_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 24;
    localparam int BEAT_W  = PIX_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    function automatic logic is_last_coord(input logic [COORD_W-1:0] c,
                                           input logic [COORD_W-1:0] n);
        return (c == (n - 10'd1));
    endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO holding loader beats as {data, eol, last}.
// The controller guarantees it never pushes into a full FIFO without a pop.
module pix_fifo2
    import img_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BEAT_W-1:0] din_i,
    output logic [BEAT_W-1:0] dout_o,
    output logic [1:0]        count_o
);

    logic [BEAT_W-1:0] ent0_q;
    logic [BEAT_W-1:0] ent1_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Occupancy update from push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent0_q   <= {BEAT_W{1'b0}};
            ent1_q   <= {BEAT_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                if (wr_ptr_q) begin
                    ent1_q <= din_i;
                end else begin
                    ent0_q <= din_i;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = rd_ptr_q ? ent1_q : ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/image_scan_ctrl.sv
// Raster-scan controller: walks a width x height window through an external
// image loader and streams the pixels out over a valid/ready interface.
module image_scan_ctrl
    import img_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] rom_x,
    output logic [COORD_W-1:0] rom_y,
    input  logic [7:0]         rom_r,
    input  logic [7:0]         rom_g,
    input  logic [7:0]         rom_b,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_eol,
    output logic               pix_last
);

    scan_state_e        state_q, state_d;
    logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] nx_s, ny_s;
    logic               a_vld_q, a_eol_q, a_last_q;
    logic               d_vld_q, d_eol_q, d_last_q;
    logic               issue_s, iss_eol_s, iss_last_s;
    logic               busy_q, busy_d, done_q, done_d;
    logic               out_vld_q, out_vld_d, out_eol_q, out_eol_d, out_last_q, out_last_d;
    logic [PIX_W-1:0]   out_data_q, out_data_d;
    logic               hs_s, start_ok_s, zero_dim_s, at_end_s, x_wrap_s, room_s;
    logic [2:0]         occ_s;
    logic [1:0]         fifo_cnt_s;
    logic               fifo_empty_s, fifo_push_s, fifo_pop_s, out_free_s;
    logic [BEAT_W-1:0]  in_beat_s, fifo_dout_s, out_src_s;

    assign hs_s       = out_vld_q & pix_ready;
    assign start_ok_s = start & (state_q == ST_IDLE);
    assign zero_dim_s = (width == 10'd0) | (height == 10'd0);
    assign x_wrap_s   = is_last_coord(x_q, w_q);
    assign at_end_s   = x_wrap_s & is_last_coord(y_q, h_q);
    assign nx_s       = x_wrap_s ? 10'd0 : (x_q + 10'd1);
    assign ny_s       = x_wrap_s ? (y_q + 10'd1) : y_q;

    // Beats held in the output register, the FIFO and the two-stage loader
    // pipeline; capacity is the output register plus two FIFO entries.
    assign occ_s  = {2'b00, out_vld_q} + {1'b0, fifo_cnt_s} + {2'b00, a_vld_q} + {2'b00, d_vld_q};
    assign room_s = (occ_s < (3'd3 + {2'b00, hs_s}));

    // Scan FSM, address generation and completion pulse.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        issue_s    = 1'b0;
        iss_eol_s  = 1'b0;
        iss_last_s = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                x_d = 10'd0;
                y_d = 10'd0;
                if (start_ok_s && zero_dim_s) begin
                    done_d = 1'b1;
                end else if (start_ok_s) begin
                    state_d    = ST_SCAN;
                    w_d        = width;
                    h_d        = height;
                    issue_s    = 1'b1;
                    iss_eol_s  = (width == 10'd1);
                    iss_last_s = (width == 10'd1) & (height == 10'd1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (at_end_s) begin
                    state_d = ST_DRAIN;
                end else if (room_s) begin
                    issue_s    = 1'b1;
                    x_d        = nx_s;
                    y_d        = ny_s;
                    iss_eol_s  = is_last_coord(nx_s, w_q);
                    iss_last_s = is_last_coord(nx_s, w_q) & is_last_coord(ny_s, h_q);
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (hs_s && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    x_d     = 10'd0;
                    y_d     = 10'd0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control registers and the loader request/response pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            w_q      <= 10'd0;
            h_q      <= 10'd0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            a_vld_q  <= 1'b0;
            a_eol_q  <= 1'b0;
            a_last_q <= 1'b0;
            d_vld_q  <= 1'b0;
            d_eol_q  <= 1'b0;
            d_last_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            h_q      <= h_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a_vld_q  <= issue_s;
            a_eol_q  <= iss_eol_s;
            a_last_q <= iss_last_s;
            d_vld_q  <= a_vld_q;
            d_eol_q  <= a_eol_q;
            d_last_q <= a_last_q;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign in_beat_s    = {rom_r, rom_g, rom_b, d_eol_q, d_last_q};
    assign fifo_empty_s = (fifo_cnt_s == 2'd0);
    assign out_free_s   = ~out_vld_q | hs_s;
    assign fifo_pop_s   = out_free_s & ~fifo_empty_s;
    assign fifo_push_s  = d_vld_q & ~(out_free_s & fifo_empty_s);
    assign out_src_s    = fifo_empty_s ? in_beat_s : fifo_dout_s;

    pix_fifo2 u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .din_i   (in_beat_s),
        .dout_o  (fifo_dout_s),
        .count_o (fifo_cnt_s)
    );

    // Output register: FIFO head has priority, else loader data bypasses.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_eol_d  = out_eol_q;
        out_last_d = out_last_q;
        if (out_free_s && (!fifo_empty_s || d_vld_q)) begin
            out_vld_d  = 1'b1;
            out_data_d = out_src_s[BEAT_W-1:2];
            out_eol_d  = out_src_s[1];
            out_last_d = out_src_s[0];
        end else if (out_free_s) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Pixel output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= {PIX_W{1'b0}};
            out_eol_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_eol_q  <= out_eol_d;
            out_last_q <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_x     = x_q;
    assign rom_y     = y_q;
    assign pix_data  = out_data_q;
    assign pix_valid = out_vld_q;
    assign pix_eol   = out_eol_q;
    assign pix_last  = out_last_q;

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Self-checking bench for image_scan_ctrl: a registered image-loader model
// feeds the DUT and every beat is compared with the raster-order expectation.
module tb_image_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  width, height;
    logic        busy, done;
    logic [9:0]  rom_x, rom_y;
    logic [7:0]  rom_r, rom_g, rom_b;
    logic [23:0] pix_data;
    logic        pix_valid, pix_ready, pix_eol, pix_last;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int w;
        int h;
        int rdy_pct;
        int inj_at;
        int exp_beats;
        int exp_done;
    } vec_t;

    vec_t vecs[10];

    image_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .width     (width),
        .height    (height),
        .busy      (busy),
        .done      (done),
        .rom_x     (rom_x),
        .rom_y     (rom_y),
        .rom_r     (rom_r),
        .rom_g     (rom_g),
        .rom_b     (rom_b),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_eol   (pix_eol),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix_of(input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'(x) ^ 8'h5A;
        g = 8'(y + 51);
        b = 8'(x + 3 * y);
        return {r, g, b};
    endfunction

    // Image loader: one-cycle registered read.
    always @(posedge clk) {rom_r, rom_g, rom_b} <= pix_of(int'(rom_x), int'(rom_y));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic run_window(input int w, input int h, input int rdy_pct,
                              input int inj_at, input int exp_beats, input int exp_done);
        int beats;
        int ex, ey;
        bit done_seen, stall;
        logic [25:0] held;
        @(negedge clk);
        width = 10'(w); height = 10'(h); start = 1'b1; pix_ready = 1'b1;
        beats = 0; done_seen = 1'b0; stall = 1'b0; held = '0;
        for (int t = 1; t <= 40 * (w * h + 2) && !done_seen; t++) begin
            @(negedge clk);
            start = (t == inj_at);
            if (t == inj_at) begin
                width = 10'd2; height = 10'd2;
            end
            if (t == 1 && exp_beats > 0) check("busy_after_start", busy, 1);
            if (stall) begin
                check("stall_valid", pix_valid, 1);
                check("stall_hold", {pix_data, pix_eol, pix_last}, held);
            end
            if (done) begin
                done_seen = 1'b1;
                check("beat_total", beats, exp_beats);
                check("busy_at_done", busy, 0);
                check("valid_at_done", pix_valid, 0);
                if (exp_done >= 0) check("done_cycle", t, exp_done);
            end else begin
                if (exp_beats == 0) check("busy_zero_dim", busy, 0);
                pix_ready = ($urandom_range(99) < rdy_pct);
                stall = 1'b0;
                if (pix_valid) begin
                    check("beat_in_range", beats < exp_beats, 1);
                    if (beats < exp_beats) begin
                        ex = beats % w;
                        ey = beats / w;
                        check("pix_data", pix_data, pix_of(ex, ey));
                        check("pix_eol", pix_eol, ex == w - 1);
                        check("pix_last", pix_last, beats == exp_beats - 1);
                        if (exp_done >= 0) check("beat_cycle", t, 3 + beats);
                    end
                    if (pix_ready) beats++;
                    else begin
                        stall = 1'b1;
                        held = {pix_data, pix_eol, pix_last};
                    end
                end
            end
        end
        check("done_seen", done_seen, 1);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_valid", pix_valid, 0);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int w, h, p;
        vecs[0] = '{3, 2, 100, 0, 6, 9};
        vecs[1] = '{1, 1, 100, 0, 1, 4};
        vecs[2] = '{1, 3, 100, 0, 3, 6};
        vecs[3] = '{5, 1, 100, 0, 5, 8};
        vecs[4] = '{0, 5, 100, 0, 0, 1};
        vecs[5] = '{7, 0, 100, 0, 0, 1};
        vecs[6] = '{4, 2, 50, 0, 8, -1};
        vecs[7] = '{3, 3, 35, 0, 9, -1};
        vecs[8] = '{3, 2, 100, 2, 6, 9};
        vecs[9] = '{2, 2, 100, 3, 4, 7};

        rst = 1'b1; start = 1'b0; width = 10'd0; height = 10'd0; pix_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_eol", pix_eol, 0);
        check("rst_last", pix_last, 0);
        check("rst_data", pix_data, 0);
        check("rst_rom_x", rom_x, 0);
        check("rst_rom_y", rom_y, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", pix_valid, 0);

        for (int i = 0; i < 10; i++)
            run_window(vecs[i].w, vecs[i].h, vecs[i].rdy_pct, vecs[i].inj_at,
                       vecs[i].exp_beats, vecs[i].exp_done);

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            p = (i % 3 == 0) ? 100 : $urandom_range(20, 90);
            run_window(w, h, p, 0, w * h, (p >= 100) ? 3 + w * h : -1);
        end

        // Reset in the middle of a 3x3 scan, then a single-pixel window.
        @(negedge clk);
        width = 10'd3; height = 10'd3; start = 1'b1; pix_ready = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_valid", pix_valid, 1);
        check("mid_data", pix_data, pix_of(2, 0));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rom_x", rom_x, 0);
        check("mid_rst_data", pix_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("after_rst_valid", pix_valid, 0);
            check("after_rst_busy", busy, 0);
        end
        run_window(1, 1, 100, 0, 1, 4);

        // Start held high through done: back-to-back 2x1 windows.
        @(negedge clk);
        width = 10'd2; height = 10'd1; start = 1'b1; pix_ready = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            bit ev, ed, eb;
            int ex;
            @(negedge clk);
            if (t == 6) start = 1'b0;
            ev = (t == 3) || (t == 4) || (t == 8) || (t == 9);
            ed = (t == 5) || (t == 10);
            eb = (t >= 1 && t <= 4) || (t >= 6 && t <= 9);
            check("b2b_valid", pix_valid, ev);
            check("b2b_done", done, ed);
            check("b2b_busy", busy, eb);
            if (ev) begin
                ex = (t == 3 || t == 8) ? 0 : 1;
                check("b2b_data", pix_data, pix_of(ex, 0));
                check("b2b_eol", pix_eol, ex == 1);
                check("b2b_last", pix_last, ex == 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
